// File: rtl/rec_frame_packer.sv
`timescale 1ns/1ps
// Serial-to-parallel packer for the ADC1/ADC2 recording streams: builds tagged
// word pairs, queues them in a small FIFO and reports truncation/overflow.
module rec_frame_packer #(
   parameter int ADC_BITS   = 10,
   parameter int FIFO_DEPTH = 8,
   parameter int FCNT_W     = 4
) (
   input  logic                           clk_i,
   input  logic                           reset_n_i,
   input  logic                           enable_i,
   input  logic                           bit_en_i,
   input  logic                           word_start_i,
   input  logic                           rec_data1_i,
   input  logic                           rec_data2_i,
   input  logic [4:0]                     adc_idx_i,
   input  logic                           clr_err_i,
   input  logic                           out_ready_i,
   output logic                           out_valid_o,
   output logic [FCNT_W+5+2*ADC_BITS-1:0] out_data_o,
   output logic [$clog2(FIFO_DEPTH):0]    fill_o,
   output logic                           err_short_o,
   output logic                           err_ovf_o
);

   localparam int OUT_W = FCNT_W + 5 + 2 * ADC_BITS;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(ADC_BITS + 1);

   typedef enum logic [0:0] {IDLE, SHIFT} state_t;

   state_t              state_q;
   logic [ADC_BITS-2:0] sr1_q, sr2_q;
   logic [CNT_W-1:0]    bcnt_q;
   logic [FCNT_W-1:0]   fcnt_q, tag_q, fcnt_inc_d;
   logic [4:0]          idx_q;
   logic                push_q;
   logic [OUT_W-1:0]    entry_q;
   logic                qstart_d, short_set_d;

   logic [OUT_W-1:0]    mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]    wptr_q, rptr_q, rptr_d;
   logic [PTR_W:0]      fill_q, fill_d;
   logic                valid_q, pop_d, push_acc_d, ovf_set_d;
   logic [OUT_W-1:0]    head_q, head_d;
   logic                err_short_q, err_ovf_q;

   assign qstart_d    = bit_en_i & word_start_i;
   assign short_set_d = enable_i & qstart_d & (state_q == SHIFT);
   assign fcnt_inc_d  = fcnt_q + 1'b1;

   // Deserialiser: a qualified start always (re)loads bit 0, even mid-word.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         sr1_q   <= '0;
         sr2_q   <= '0;
         bcnt_q  <= '0;
         fcnt_q  <= '0;
         tag_q   <= '0;
         idx_q   <= '0;
         push_q  <= 1'b0;
         entry_q <= '0;
      end else begin
         push_q <= 1'b0;
         if (!enable_i) begin
            state_q <= IDLE;
            sr1_q   <= '0;
            sr2_q   <= '0;
            bcnt_q  <= '0;
         end else if (qstart_d) begin
            state_q <= SHIFT;
            sr1_q   <= {{(ADC_BITS-2){1'b0}}, rec_data1_i};
            sr2_q   <= {{(ADC_BITS-2){1'b0}}, rec_data2_i};
            bcnt_q  <= CNT_W'(1);
            idx_q   <= adc_idx_i;
            if (adc_idx_i == 5'd0) begin
               fcnt_q <= fcnt_inc_d;
               tag_q  <= fcnt_inc_d;
            end else begin
               tag_q  <= fcnt_q;
            end
         end else if (state_q == SHIFT && bit_en_i) begin
            if (bcnt_q == CNT_W'(ADC_BITS - 1)) begin
               push_q  <= 1'b1;
               entry_q <= {tag_q, idx_q, sr2_q, rec_data2_i, sr1_q, rec_data1_i};
               state_q <= IDLE;
               bcnt_q  <= '0;
            end else begin
               sr1_q  <= {sr1_q[ADC_BITS-3:0], rec_data1_i};
               sr2_q  <= {sr2_q[ADC_BITS-3:0], rec_data2_i};
               bcnt_q <= bcnt_q + 1'b1;
            end
         end
      end
   end

   // The head register is loaded from next-cycle FIFO state, bypassing the
   // memory when the entry being written becomes the new head.
   always_comb begin
      pop_d      = valid_q & out_ready_i;
      push_acc_d = push_q & ((fill_q != (PTR_W+1)'(FIFO_DEPTH)) | pop_d);
      ovf_set_d  = push_q & ~push_acc_d;
      rptr_d     = pop_d ? rptr_q + 1'b1 : rptr_q;
      fill_d     = fill_q;
      if (push_acc_d && !pop_d) begin
         fill_d = fill_q + 1'b1;
      end else if (pop_d && !push_acc_d) begin
         fill_d = fill_q - 1'b1;
      end
      head_d = '0;
      if (fill_d != '0) begin
         head_d = (push_acc_d && (wptr_q == rptr_d)) ? entry_q : mem_q[rptr_d];
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_acc_d) begin
         mem_q[wptr_q] <= entry_q;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         fill_q      <= '0;
         valid_q     <= 1'b0;
         head_q      <= '0;
         err_short_q <= 1'b0;
         err_ovf_q   <= 1'b0;
      end else begin
         if (push_acc_d) begin
            wptr_q <= wptr_q + 1'b1;
         end
         rptr_q      <= rptr_d;
         fill_q      <= fill_d;
         valid_q     <= (fill_d != '0);
         head_q      <= head_d;
         err_short_q <= short_set_d | (err_short_q & ~clr_err_i);
         err_ovf_q   <= ovf_set_d | (err_ovf_q & ~clr_err_i);
      end
   end

   assign out_valid_o = valid_q;
   assign out_data_o  = head_q;
   assign fill_o      = fill_q;
   assign err_short_o = err_short_q;
   assign err_ovf_o   = err_ovf_q;

endmodule

// File: tb/tb_rec_frame_packer.sv
`timescale 1ns/1ps
// Randomised bench for rec_frame_packer: a word-level queue model predicts every
// output each cycle, and literal expectations pin the key scenarios.
module tb_rec_frame_packer;

   localparam int ADC_BITS   = 10;
   localparam int FIFO_DEPTH = 8;
   localparam int FCNT_W     = 4;
   localparam int OUT_W      = FCNT_W + 5 + 2 * ADC_BITS;

   logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0, bit_en = 1'b0, word_start = 1'b0;
   logic rec1 = 1'b0, rec2 = 1'b0, clr_err = 1'b0, out_ready = 1'b0;
   logic [4:0] adc_idx = '0;
   logic out_valid, err_short, err_ovf;
   logic [OUT_W-1:0] out_data;
   logic [$clog2(FIFO_DEPTH):0] fill;

   int checks = 0, errors = 0, cyc = 0;

   // Model state: expected FIFO contents, scheduled pushes, sticky flags.
   logic [OUT_W-1:0] mq[$];
   int               sq_cyc[$];
   logic [OUT_W-1:0] sq_e[$];
   logic             m_es = 1'b0, m_eo = 1'b0;
   logic             mpop, mpush, movf;
   logic [OUT_W-1:0] me;

   // Driver-side knowledge used by the model.
   logic              drv_short = 1'b0, partial = 1'b0;
   logic [FCNT_W-1:0] fc = '0;
   logic              rand_ready = 1'b0, cmp_en = 1'b0;
   logic [OUT_W-1:0]  popped[$];
   logic [ADC_BITS-1:0] wa, wb;
   int n1, n2;

   rec_frame_packer #(.ADC_BITS(ADC_BITS), .FIFO_DEPTH(FIFO_DEPTH), .FCNT_W(FCNT_W)) dut (
      .clk_i(clk), .reset_n_i(reset_n), .enable_i(enable), .bit_en_i(bit_en),
      .word_start_i(word_start), .rec_data1_i(rec1), .rec_data2_i(rec2),
      .adc_idx_i(adc_idx), .clr_err_i(clr_err), .out_ready_i(out_ready),
      .out_valid_o(out_valid), .out_data_o(out_data), .fill_o(fill),
      .err_short_o(err_short), .err_ovf_o(err_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [ADC_BITS-1:0] rw();
      return ADC_BITS'($urandom);
   endfunction

   // Queue model: bounded FIFO with pop-before-push acceptance.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mq.delete();
         sq_cyc.delete();
         sq_e.delete();
         m_es = 1'b0;
         m_eo = 1'b0;
      end else begin
         cyc++;
         mpop  = (mq.size() != 0) && out_ready;
         mpush = 1'b0;
         me    = '0;
         if (sq_cyc.size() != 0 && sq_cyc[0] == cyc) begin
            mpush = 1'b1;
            me    = sq_e.pop_front();
            void'(sq_cyc.pop_front());
         end
         movf = mpush && !((mq.size() < FIFO_DEPTH) || mpop);
         if (mpop) void'(mq.pop_front());
         if (mpush && !movf) mq.push_back(me);
         m_es = (drv_short && enable) || (m_es && !clr_err);
         m_eo = movf || (m_eo && !clr_err);
      end
   end

   always begin
      @(negedge clk);
      #2;
      if (cmp_en && reset_n) begin
         chk("valid", out_valid, mq.size() != 0);
         chk("fill", fill, mq.size());
         if (mq.size() != 0) chk("data", out_data, mq[0]);
         chk("err_short", err_short, m_es);
         chk("err_ovf", err_ovf, m_eo);
         if (out_valid && out_ready) popped.push_back(out_data);
      end
   end

   task automatic step();
      @(negedge clk);
      if (rand_ready) out_ready = ($urandom_range(3) != 0);
   endtask

   task automatic send_word(input logic [4:0] idx, input logic [ADC_BITS-1:0] d1,
                            input logic [ADC_BITS-1:0] d2, input int nbits, input int gap);
      logic [FCNT_W-1:0] tag;
      tag = fc;
      for (int b = 0; b < nbits; b++) begin
         step();
         bit_en     = 1'b1;
         word_start = (b == 0);
         rec1       = d1[ADC_BITS-1-b];
         rec2       = d2[ADC_BITS-1-b];
         drv_short  = (b == 0) && partial;
         if (b == 0) begin
            adc_idx = idx;
            if (idx == 5'd0) fc = fc + 1'b1;
            tag     = fc;
            partial = 1'b1;
         end
         if (b == nbits - 1 && nbits == ADC_BITS) begin
            sq_cyc.push_back(cyc + 2);
            sq_e.push_back({tag, idx, d2, d1});
            partial = 1'b0;
         end
         if (b < nbits - 1) begin
            for (int g = 0; g < gap; g++) begin
               step();
               bit_en = 1'b0; word_start = 1'b0; drv_short = 1'b0;
            end
         end
      end
      step();
      bit_en = 1'b0; word_start = 1'b0; drv_short = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
         step();
         #1;
         n++;
      end
      chk(name, out_valid, 1'b1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      out_ready = 1'b1;
      repeat (4) step();
      while (fill != 0 && n < 100) begin
         step();
         n++;
      end
      chk("drain_empty", fill, 0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #3;
      reset_n = 1'b0;
      fc = '0; partial = 1'b0; bit_en = 1'b0; word_start = 1'b0; drv_short = 1'b0;
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_fill", fill, 0);
      chk("rst_short", err_short, 0);
      chk("rst_ovf", err_ovf, 0);
      repeat (2) @(negedge clk);
      #3;
      reset_n = 1'b1;
   endtask

   initial begin
      enable = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("init_valid", out_valid, 0);
      chk("init_data", out_data, 0);
      chk("init_fill", fill, 0);
      chk("init_errs", {err_short, err_ovf}, 0);
      #2;
      reset_n = 1'b1;
      cmp_en  = 1'b1;

      // Basic word, one strobe every 2 cycles, two-cycle latency.
      out_ready = 1'b1;
      send_word(5'd0, 10'h2A5, 10'h15A, ADC_BITS, 1);
      #1 chk("t1_not_yet", out_valid, 0);
      step();
      #1;
      chk("t1_valid", out_valid, 1);
      chk("t1_data", out_data, {4'h1, 5'd0, 10'h15A, 10'h2A5});

      // 64 words, idx 0..31 twice, random gaps and ready.
      pulse_reset();
      popped.delete();
      rand_ready = 1'b1;
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < 32; i++)
            send_word(5'(i), rw(), rw(), ADC_BITS, $urandom_range(2));
      rand_ready = 1'b0;
      drain();
      n1 = 0; n2 = 0;
      foreach (popped[k]) begin
         if (popped[k][OUT_W-1 -: FCNT_W] == 4'd1) n1++;
         else if (popped[k][OUT_W-1 -: FCNT_W] == 4'd2) n2++;
      end
      chk("t2_frame1", n1, 32);
      chk("t2_frame2", n2, 32);
      chk("t2_errs", {err_short, err_ovf}, 0);

      // Overflow: 9 words into 8 entries with ready low.
      popped.delete();
      out_ready = 1'b0;
      for (int i = 0; i < 9; i++) send_word(5'(10 + i), rw(), rw(), ADC_BITS, 0);
      repeat (3) step();
      #1;
      chk("t3_fill", fill, 8);
      chk("t3_ovf", err_ovf, 1);
      drain();
      chk("t3_count", popped.size(), 8);
      foreach (popped[k]) chk("t3_order", popped[k][2*ADC_BITS +: 5], 10 + k);

      // Full FIFO with simultaneous push and pop, then set-beats-clear.
      clr_err = 1'b1; step(); clr_err = 1'b0;
      popped.delete();
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) send_word(5'(i + 1), rw(), rw(), ADC_BITS, 0);
      send_word(5'd20, rw(), rw(), ADC_BITS, 0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      #1;
      chk("t4_fill", fill, 8);
      chk("t4_no_ovf", err_ovf, 0);
      send_word(5'd21, rw(), rw(), ADC_BITS, 0);
      repeat (2) step();
      #1 chk("t4_ovf_set", err_ovf, 1);
      send_word(5'd22, rw(), rw(), ADC_BITS, 0);
      clr_err = 1'b1; step(); clr_err = 1'b0;
      #1 chk("t4_ovf_hold", err_ovf, 1);
      clr_err = 1'b1; step(); clr_err = 1'b0;
      #1 chk("t4_ovf_clr", err_ovf, 0);
      drain();
      chk("t4_count", popped.size(), 9);
      chk("t4_last", popped[popped.size()-1][2*ADC_BITS +: 5], 20);

      // Enable drop discards silently; a mid-word start truncates.
      clr_err = 1'b1; step(); clr_err = 1'b0;
      popped.delete();
      out_ready = 1'b1;
      send_word(5'd7, rw(), rw(), 5, 0);
      enable = 1'b0; partial = 1'b0;
      repeat (2) step();
      enable = 1'b1;
      send_word(5'd9, rw(), rw(), ADC_BITS, 1);
      #1 chk("t5_no_short", err_short, 0);
      send_word(5'd3, rw(), rw(), 6, 1);
      send_word(5'd5, 10'h3FF, 10'h001, ADC_BITS, 1);
      repeat (3) step();
      #1;
      chk("t5_short", err_short, 1);
      chk("t5_count", popped.size(), 2);
      chk("t5_first", popped[0][2*ADC_BITS +: 5], 9);
      chk("t5_word", popped[1][2*ADC_BITS+4:0], {5'd5, 10'h001, 10'h3FF});

      // Reset mid-word with three entries buffered.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send_word(5'(i + 1), rw(), rw(), ADC_BITS, 0);
      send_word(5'd2, rw(), rw(), 4, 0);
      #1 chk("t6_fill", fill, 3);
      pulse_reset();
      wa = rw(); wb = rw();
      send_word(5'd0, wa, wb, ADC_BITS, 0);
      wait_valid("t6_valid");
      chk("t6_data", out_data, {4'h1, 5'd0, wb, wa});
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at time limit");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
